// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response bundle between the MEM stage and the data-memory responder
interface data_mem_responder_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              req_ready;
   logic              resp_valid;
   logic              resp_write;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              stall;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_write, resp_rdata, resp_err, stall
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_write, resp_rdata, resp_err, stall
   );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency word-addressed data RAM answering MEM-stage loads and stores
module data_mem_responder #(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 32,
   parameter int LATENCY = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   data_mem_responder_if.slave  bus
);
   localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
   localparam logic [3:0]        CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state, state_nx;
   logic [3:0]        cnt, cnt_nx;
   logic              hold_write;
   logic [ADDR_W-1:0] hold_addr;
   logic [31:0]       hold_wdata;
   logic              hold_err;
   logic [IDX_W-1:0]  hold_idx;
   logic [31:0]       ram [DEPTH];

   logic              accept;
   logic              commit;
   logic              src_write;
   logic [ADDR_W-1:0] src_addr;
   logic              src_err;
   logic [IDX_W-1:0]  src_idx;
   logic [31:0]       rd_word;

   assign bus.req_ready = (state != BUSY);
   assign bus.stall     = bus.req_valid & (state == BUSY);
   assign accept        = bus.req_valid & (state != BUSY);

   assign hold_err = (hold_addr >= DEPTH_A);
   assign hold_idx = hold_addr[IDX_W-1:0];
   assign commit   = (state == RESP) & hold_write & ~hold_err;

   // The request being answered next cycle: the live inputs when LATENCY=1
   // accepts straight into RESP, otherwise the captured copy.
   assign src_write = accept ? bus.req_write : hold_write;
   assign src_addr  = accept ? bus.req_addr  : hold_addr;
   assign src_err   = (src_addr >= DEPTH_A);
   assign src_idx   = src_addr[IDX_W-1:0];

   // A store commits on the same edge that registers the next load's data.
   assign rd_word = (commit && (hold_idx == src_idx)) ? hold_wdata : ram[src_idx];

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE, RESP: begin
            if (accept) begin
               cnt_nx   = CNT_LOAD;
               state_nx = (LATENCY == 1) ? RESP : BUSY;
            end else begin
               state_nx = IDLE;
            end
         end
         BUSY: begin
            cnt_nx = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nx = RESP;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_write <= 1'b0;
         hold_addr  <= '0;
         hold_wdata <= 32'd0;
      end else if (accept) begin
         hold_write <= bus.req_write;
         hold_addr  <= bus.req_addr;
         hold_wdata <= bus.req_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.resp_valid <= 1'b0;
         bus.resp_write <= 1'b0;
         bus.resp_err   <= 1'b0;
         bus.resp_rdata <= 32'd0;
      end else if (state_nx == RESP) begin
         bus.resp_valid <= 1'b1;
         bus.resp_write <= src_write;
         bus.resp_err   <= src_err;
         bus.resp_rdata <= (src_write | src_err) ? 32'd0 : rd_word;
      end else begin
         bus.resp_valid <= 1'b0;
         bus.resp_write <= 1'b0;
         bus.resp_err   <= 1'b0;
         bus.resp_rdata <= 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (commit) begin
         ram[hold_idx] <= hold_wdata;
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - bench for data_mem_responder at LATENCY=3 and LATENCY=1
module tb_data_mem_responder;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   data_mem_responder_if #(.ADDR_W(32)) bus3 ();
   data_mem_responder_if #(.ADDR_W(32)) bus1 ();

   data_mem_responder #(.DEPTH(256), .ADDR_W(32), .LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
   data_mem_responder #(.DEPTH(256), .ADDR_W(32), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   typedef struct {
      logic        wr;
      logic        err;
      logic [31:0] rdata;
      int          due;
   } exp_t;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   exp_t q0[$];
   exp_t q1[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   acc[2];
   int   lat[2];
   logic v[2];
   logic w[2];
   logic [31:0] a[2];
   logic [31:0] d[2];

   assign bus3.req_valid = v[0];
   assign bus3.req_write = w[0];
   assign bus3.req_addr  = a[0];
   assign bus3.req_wdata = d[0];
   assign bus1.req_valid = v[1];
   assign bus1.req_write = w[1];
   assign bus1.req_addr  = a[1];
   assign bus1.req_wdata = d[1];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, req);
      end
   endtask

   task automatic mon(int s, logic rv, logic rw, logic re, logic [31:0] rd, logic rr, logic st);
      exp_t e;
      logic er;
      int   n;
      er = !(cyc > acc[s] && cyc < acc[s] + lat[s]);
      check($sformatf("req_ready%0d", s), 32'(rr), 32'(er));
      check($sformatf("stall%0d", s), 32'(st), 32'(v[s] & ~er));
      if (rv) begin
         n = (s == 0) ? q0.size() : q1.size();
         if (n == 0) begin
            check($sformatf("unexpected_resp%0d", s), 32'(1), 32'(0));
         end else begin
            if (s == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("resp_cycle%0d", s), 32'(cyc), 32'(e.due));
            check($sformatf("resp_write%0d", s), 32'(rw), 32'(e.wr));
            check($sformatf("resp_err%0d", s), 32'(re), 32'(e.err));
            check($sformatf("resp_rdata%0d", s), rd, e.rdata);
         end
      end else begin
         check($sformatf("idle_flags%0d", s), 32'({rw, re}), 32'(0));
         check($sformatf("idle_rdata%0d", s), rd, 32'(0));
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0, bus3.resp_valid, bus3.resp_write, bus3.resp_err, bus3.resp_rdata, bus3.req_ready, bus3.stall);
         mon(1, bus1.resp_valid, bus1.resp_write, bus1.resp_err, bus1.resp_rdata, bus1.req_ready, bus1.stall);
      end
   end

   // Leaves the request asserted on return; callers chain or call idle().
   task automatic drive(int s, logic wr, logic [31:0] ad, logic [31:0] wd,
                        logic ee, logic [31:0] erd, output int at);
      exp_t e;
      bit   ok;
      logic rdy;
      ok = 0;
      at = -1;
      v[s] = 1'b1; w[s] = wr; a[s] = ad; d[s] = wd;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         rdy = (s == 0) ? bus3.req_ready : bus1.req_ready;
         if (rdy) begin
            ok = 1;
            at = cyc;
            acc[s] = cyc;
            e = '{wr, ee, erd, cyc + lat[s]};
            if (s == 0) q0.push_back(e);
            else        q1.push_back(e);
         end
         @(posedge clk); #1;
      end
      if (!ok) check($sformatf("accept_timeout%0d", s), 32'(0), 32'(1));
   endtask

   task automatic idle(int s);
      v[s] = 1'b0;
   endtask

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 60 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
      #1;
      check("drain_q0", 32'(q0.size()), 32'(0));
      check("drain_q1", 32'(q1.size()), 32'(0));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      v[0] = 1'b0; v[1] = 1'b0;
      q0.delete(); q1.delete();
      acc[0] = -100; acc[1] = -100;
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_ready3"}, 32'(bus3.req_ready), 32'(1));
      check({tag, "_valid3"}, 32'({bus3.resp_valid, bus3.resp_write, bus3.resp_err}), 32'(0));
      check({tag, "_rdata3"}, bus3.resp_rdata, 32'(0));
      check({tag, "_ready1"}, 32'(bus1.req_ready), 32'(1));
      check({tag, "_valid1"}, 32'({bus1.resp_valid, bus1.resp_write, bus1.resp_err}), 32'(0));
   endtask

   initial begin
      vec_t tbl[12];
      int   at, prev;
      bit   seen;

      lat[0] = 3; lat[1] = 1;
      w[0] = 1'b0; w[1] = 1'b0; a[0] = 32'd0; a[1] = 32'd0; d[0] = 32'd0; d[1] = 32'd0;
      do_reset();
      #2;
      check_reset_outputs("reset");
      step(2);
      rst = 1'b0;

      tbl[0]  = '{1'b1, 32'd5,          32'hDEADBEEF, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 32'd5,          32'h0,        1'b0, 32'hDEADBEEF};
      tbl[2]  = '{1'b1, 32'd44,         32'h44444444, 1'b0, 32'h0};
      tbl[3]  = '{1'b1, 32'd7,          32'h00000077, 1'b0, 32'h0};
      tbl[4]  = '{1'b1, 32'd300,        32'hBAD00BAD, 1'b1, 32'h0};
      tbl[5]  = '{1'b0, 32'd300,        32'h0,        1'b1, 32'h0};
      tbl[6]  = '{1'b0, 32'd44,         32'h0,        1'b0, 32'h44444444};
      tbl[7]  = '{1'b1, 32'd255,        32'hCAFEF00D, 1'b0, 32'h0};
      tbl[8]  = '{1'b0, 32'd255,        32'h0,        1'b0, 32'hCAFEF00D};
      tbl[9]  = '{1'b1, 32'd256,        32'h00000001, 1'b1, 32'h0};
      tbl[10] = '{1'b0, 32'h80000005,   32'h0,        1'b1, 32'h0};
      tbl[11] = '{1'b0, 32'd5,          32'h0,        1'b0, 32'hDEADBEEF};

      for (int i = 0; i < 12; i++) begin
         drive(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].err, tbl[i].rdata, at);
         idle(0);
         step($urandom_range(0, 2));
      end
      drain();

      // Held request line: one acceptance every 3 cycles, store then RAW load.
      drive(0, 1'b1, 32'd9, 32'h0000900D, 1'b0, 32'h0, prev);
      drive(0, 1'b0, 32'd9, 32'h0, 1'b0, 32'h0000900D, at);
      check("b2b_spacing0", 32'(at - prev), 32'(3));
      prev = at;
      drive(0, 1'b0, 32'd5, 32'h0, 1'b0, 32'hDEADBEEF, at);
      check("b2b_spacing1", 32'(at - prev), 32'(3));
      prev = at;
      drive(0, 1'b0, 32'd44, 32'h0, 1'b0, 32'h44444444, at);
      check("b2b_spacing2", 32'(at - prev), 32'(3));
      idle(0);
      drain();

      // Inputs wiggle while BUSY; response and RAM follow only the captured load.
      drive(0, 1'b0, 32'd7, 32'h0, 1'b0, 32'h00000077, at);
      w[0] = 1'b1; a[0] = 32'd5; d[0] = 32'h0BAD0BAD;
      step(1);
      v[0] = 1'b0; a[0] = 32'd6;
      drain();
      drive(0, 1'b0, 32'd5, 32'h0, 1'b0, 32'hDEADBEEF, at);
      idle(0);
      drain();

      // Reset while BUSY: store dropped, no response afterwards.
      drive(0, 1'b1, 32'd7, 32'h00005555, 1'b0, 32'h0, at);
      idle(0);
      #2;
      do_reset();
      #1;
      check_reset_outputs("busy_reset");
      step(1);
      rst = 1'b0;
      step(6);
      drive(0, 1'b0, 32'd7, 32'h0, 1'b0, 32'h00000077, at);
      idle(0);
      drain();

      // Reset during RESP: outputs clear at once and the store never commits.
      drive(0, 1'b1, 32'd7, 32'h00006666, 1'b0, 32'h0, at);
      idle(0);
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (bus3.resp_valid) seen = 1;
      end
      check("resp_before_reset", 32'(seen), 32'(1));
      #1;
      do_reset();
      #1;
      check_reset_outputs("resp_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      drive(0, 1'b0, 32'd7, 32'h0, 1'b0, 32'h00000077, at);
      idle(0);
      drain();

      // LATENCY=1 streaming: store/load to addr 0 every cycle.
      prev = -1;
      for (int i = 1; i <= 6; i++) begin
         drive(1, 1'b1, 32'd0, 32'(i), 1'b0, 32'h0, at);
         if (prev >= 0) check("stream_spacing_st", 32'(at - prev), 32'(1));
         prev = at;
         drive(1, 1'b0, 32'd0, 32'h0, 1'b0, 32'(i), at);
         check("stream_spacing_ld", 32'(at - prev), 32'(1));
         prev = at;
      end
      idle(1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
